// File: rtl/nios_system_dp_descriptor_ram_if.sv
// Avalon-MM slave bundle for one port of the dual-port descriptor RAM.
// The master side drives the command; the slave side returns data and stall.
interface nios_system_dp_descriptor_ram_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10
);
  logic [ADDR_WIDTH-1:0]   address;
  logic                    chipselect;
  logic                    read;
  logic                    write;
  logic [DATA_WIDTH/8-1:0] byteenable;
  logic [DATA_WIDTH-1:0]   writedata;
  logic [DATA_WIDTH-1:0]   readdata;
  logic                    readdatavalid;
  logic                    waitrequest;

  modport master (
    output address, chipselect, read, write, byteenable, writedata,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  address, chipselect, read, write, byteenable, writedata,
    output readdata, readdatavalid, waitrequest
  );
endinterface

// File: rtl/nios_system_dp_descriptor_ram.sv
// Dual-port descriptor RAM: two Avalon-MM slaves on one array, byte-lane writes,
// pipelined reads with readdatavalid and a zero-fill engine that stalls both ports.
module nios_system_dp_descriptor_ram #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned DEPTH          = 1024,
  parameter int unsigned READ_LATENCY   = 1,
  parameter bit          CLEAR_ON_RESET = 1'b1,
  parameter string       INIT_FILE      = "nios_system_dp_descriptor_ram.hex"
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear_req,
  output logic clear_busy,
  nios_system_dp_descriptor_ram_if.slave s1,
  nios_system_dp_descriptor_ram_if.slave s2
);
  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned IDXW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned NPORT = 2;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] LAST_W  = (ADDR_WIDTH + 1)'(DEPTH - 1);

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [ADDR_WIDTH:0]   r_fill_cnt;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic [ADDR_WIDTH-1:0] w_addr  [NPORT];
  logic [IDXW-1:0]       w_idx   [NPORT];
  logic [BYTES-1:0]      w_be    [NPORT];
  logic [DATA_WIDTH-1:0] w_wdata [NPORT];
  logic [NPORT-1:0]      w_cs, w_rd, w_wr, w_in_range, w_we, w_re;

  logic [NPORT-1:0]      r_pv [READ_LATENCY];
  logic [DATA_WIDTH-1:0] r_pd [NPORT][READ_LATENCY];
  logic [NPORT-1:0]      r_rvalid;
  logic [DATA_WIDTH-1:0] r_rdata [NPORT];

  // Preload images come from the tool flow; with no image the array powers up undefined.
  if (INIT_FILE == "") begin : g_no_image
  end

  always_comb begin
    w_addr[0]  = s1.address;    w_addr[1]  = s2.address;
    w_be[0]    = s1.byteenable; w_be[1]    = s2.byteenable;
    w_wdata[0] = s1.writedata;  w_wdata[1] = s2.writedata;
    w_cs       = {s2.chipselect, s1.chipselect};
    w_rd       = {s2.read, s1.read};
    w_wr       = {s2.write, s1.write};
    for (int unsigned p = 0; p < NPORT; p++) begin
      w_idx[p]      = w_addr[p][IDXW-1:0];
      w_in_range[p] = ({1'b0, w_addr[p]} < DEPTH_W);
    end
    // A write wins over a simultaneous read on the same port.
    w_we = w_cs & w_wr & ~{NPORT{clear_busy}} & w_in_range;
    w_re = w_cs & w_rd & ~w_wr & ~{NPORT{clear_busy}};
  end

  // s1 lanes are assigned last so they override s2 on a same-address overlap.
  always_ff @(posedge clk) begin
    if (r_state == ST_CLEAR) begin
      r_mem[r_fill_cnt[IDXW-1:0]] <= '0;
    end else begin
      for (int unsigned b = 0; b < BYTES; b++) begin
        if (w_we[1] && w_be[1][b]) r_mem[w_idx[1]][8*b +: 8] <= w_wdata[1][8*b +: 8];
        if (w_we[0] && w_be[0][b]) r_mem[w_idx[0]][8*b +: 8] <= w_wdata[0][8*b +: 8];
      end
    end
  end

  // Stage 0 samples the array at the accepting edge, so reads see the pre-write word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < READ_LATENCY; i++) begin
        r_pv[i] <= '0;
        for (int unsigned p = 0; p < NPORT; p++) r_pd[p][i] <= '0;
      end
      r_rvalid <= '0;
      for (int unsigned p = 0; p < NPORT; p++) r_rdata[p] <= '0;
    end else begin
      r_pv[0] <= w_re;
      for (int unsigned i = 1; i < READ_LATENCY; i++) r_pv[i] <= r_pv[i-1];
      for (int unsigned p = 0; p < NPORT; p++) begin
        r_pd[p][0] <= w_in_range[p] ? r_mem[w_idx[p]] : '0;
        for (int unsigned i = 1; i < READ_LATENCY; i++) r_pd[p][i] <= r_pd[p][i-1];
        if (r_pv[READ_LATENCY-1][p]) r_rdata[p] <= r_pd[p][READ_LATENCY-1];
      end
      r_rvalid <= r_pv[READ_LATENCY-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fill_cnt <= '0;
    end else if (r_state == ST_CLEAR && w_next_state == ST_CLEAR) begin
      r_fill_cnt <= r_fill_cnt + 1'b1;
    end else begin
      r_fill_cnt <= '0;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (clear_req) w_next_state = ST_CLEAR;
      ST_CLEAR: if (r_fill_cnt == LAST_W) w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    clear_busy = (r_state == ST_CLEAR);
  end

  assign s1.readdata      = r_rdata[0];
  assign s1.readdatavalid = r_rvalid[0];
  assign s1.waitrequest   = clear_busy;
  assign s2.readdata      = r_rdata[1];
  assign s2.readdatavalid = r_rvalid[1];
  assign s2.waitrequest   = clear_busy;
endmodule

// File: tb/tb_nios_system_dp_descriptor_ram.sv
// Directed bench for the dual-port descriptor RAM (READ_LATENCY=2, ADDR_WIDTH=11, DEPTH=1024).
module tb_nios_system_dp_descriptor_ram;
  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 11;
  localparam int unsigned DEPTH = 1024;
  localparam int unsigned RL    = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic clear_req = 1'b0;
  logic clear_busy;

  nios_system_dp_descriptor_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) s1_if ();
  nios_system_dp_descriptor_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) s2_if ();

  nios_system_dp_descriptor_ram #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .READ_LATENCY(RL),
    .CLEAR_ON_RESET(1'b1), .INIT_FILE("nios_system_dp_descriptor_ram.hex")
  ) dut (
    .clk(clk), .reset_n(reset_n), .clear_req(clear_req), .clear_busy(clear_busy),
    .s1(s1_if), .s2(s2_if)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input int p, input logic cs, input logic rd, input logic wr,
                       input logic [AW-1:0] a, input logic [3:0] be, input logic [31:0] d);
    if (p == 1) begin
      s1_if.chipselect = cs; s1_if.read = rd; s1_if.write = wr;
      s1_if.address = a; s1_if.byteenable = be; s1_if.writedata = d;
    end else begin
      s2_if.chipselect = cs; s2_if.read = rd; s2_if.write = wr;
      s2_if.address = a; s2_if.byteenable = be; s2_if.writedata = d;
    end
  endtask

  task automatic idle(input int p);
    drive(p, 1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  function automatic logic get_valid(input int p);
    return (p == 1) ? s1_if.readdatavalid : s2_if.readdatavalid;
  endfunction

  function automatic logic [31:0] get_data(input int p);
    return (p == 1) ? s1_if.readdata : s2_if.readdata;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wr(input int p, input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
    drive(p, 1'b1, 1'b0, 1'b1, a, be, d);
    step();
    idle(p);
  endtask

  task automatic wait_valid(input int p, output logic [31:0] d, output int lat);
    lat = 0;
    while (!get_valid(p) && lat < 8) begin
      step();
      lat++;
    end
    d = get_data(p);
  endtask

  task automatic rd(input int p, input logic [AW-1:0] a, output logic [31:0] d, output int lat);
    drive(p, 1'b1, 1'b1, 1'b0, a, '0, '0);
    step();
    idle(p);
    wait_valid(p, d, lat);
  endtask

  task automatic rd_chk(input string tag, input int p, input logic [AW-1:0] a, input logic [31:0] exp);
    logic [31:0] d;
    int lat;
    rd(p, a, d, lat);
    chk({tag, " data"}, d, exp);
    chk({tag, " latency"}, 32'(lat), 32'(RL));
  endtask

  task automatic count_busy(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (clear_busy && n < 3000);
  endtask

  initial begin
    logic [31:0] d, acc, vdata;
    int lat, n, nv, cyc, vcnt, vcyc, wait_bad;

    idle(1);
    idle(2);

    // T1: reset state, fill length, whole array reads zero
    repeat (2) step();
    chk("rst busy", 32'(clear_busy), 32'd1);
    chk("rst waitreq", 32'(s1_if.waitrequest), 32'd1);
    chk("rst rvalid", 32'(s1_if.readdatavalid), 32'd0);
    chk("rst rdata", s2_if.readdata, 32'h0);
    reset_n = 1'b1;
    count_busy(n);
    chk("T1 fill cycles", 32'(n), 32'd1024);
    acc = '0;
    nv = 0;
    for (int i = 0; i < int'(DEPTH + RL + 1); i++) begin
      if (i < int'(DEPTH)) drive(1, 1'b1, 1'b1, 1'b0, AW'(i), '0, '0);
      else idle(1);
      step();
      if (s1_if.readdatavalid) begin
        nv++;
        acc |= s1_if.readdata;
      end
    end
    chk("T1 valid count", 32'(nv), 32'd1024);
    chk("T1 all zero", acc, 32'h0);

    // T2: byte-lane merge, cross-port read, latency and pulse width
    wr(1, 11'd5, 32'hDEADBEEF, 4'hF);
    wr(1, 11'd5, 32'h0000AA00, 4'b0010);
    rd(2, 11'd5, d, lat);
    chk("T2 data", d, 32'hDEADAAEF);
    chk("T2 latency", 32'(lat), 32'd2);
    step();
    chk("T2 pulse width", 32'(s2_if.readdatavalid), 32'd0);
    chk("T2 hold", s2_if.readdata, 32'hDEADAAEF);

    // T3: same-address writes, s1 wins its lanes
    drive(1, 1'b1, 1'b0, 1'b1, 11'd9, 4'b0011, 32'h11111111);
    drive(2, 1'b1, 1'b0, 1'b1, 11'd9, 4'b1111, 32'h22222222);
    step();
    idle(1);
    idle(2);
    rd_chk("T3", 1, 11'd9, 32'h22221111);

    // T4: read-during-write across ports returns the old word
    wr(1, 11'd3, 32'h7, 4'hF);
    drive(1, 1'b1, 1'b0, 1'b1, 11'd3, 4'hF, 32'h5);
    drive(2, 1'b1, 1'b1, 1'b0, 11'd3, '0, '0);
    step();
    idle(1);
    idle(2);
    wait_valid(2, d, lat);
    chk("T4 old word", d, 32'h7);
    rd_chk("T4 new word", 2, 11'd3, 32'h5);

    // back-to-back reads on one port
    drive(1, 1'b1, 1'b1, 1'b0, 11'd5, '0, '0);
    step();
    drive(1, 1'b1, 1'b1, 1'b0, 11'd9, '0, '0);
    step();
    idle(1);
    chk("b2b early", 32'(s1_if.readdatavalid), 32'd0);
    step();
    chk("b2b v0", 32'(s1_if.readdatavalid), 32'd1);
    chk("b2b d0", s1_if.readdata, 32'hDEADAAEF);
    step();
    chk("b2b v1", 32'(s1_if.readdatavalid), 32'd1);
    chk("b2b d1", s1_if.readdata, 32'h22221111);
    step();
    chk("b2b end", 32'(s1_if.readdatavalid), 32'd0);

    // read and write together: write happens, no readdatavalid
    drive(1, 1'b1, 1'b1, 1'b1, 11'd20, 4'hF, 32'h0000CAFE);
    step();
    idle(1);
    nv = 0;
    repeat (4) begin
      step();
      if (s1_if.readdatavalid) nv++;
    end
    chk("rw no valid", 32'(nv), 32'd0);
    rd_chk("rw written", 1, 11'd20, 32'h0000CAFE);

    // out-of-range accesses
    wr(1, 11'd6, 32'h00000066, 4'hF);
    wr(2, 11'd1030, 32'hFFFFFFFF, 4'hF);
    rd_chk("oor alias kept", 1, 11'd6, 32'h00000066);
    rd_chk("oor read 1030", 2, 11'd1030, 32'h0);

    // T5: clear request with a read in flight, second request ignored
    wr(1, 11'd7, 32'h12345678, 4'hF);
    drive(1, 1'b1, 1'b1, 1'b0, 11'd5, '0, '0);
    clear_req = 1'b1;
    step();
    idle(1);
    clear_req = 1'b0;
    cyc = 0; n = 0; vcnt = 0; vcyc = -1; vdata = '0; wait_bad = 0;
    while (clear_busy && cyc < 2000) begin
      n++;
      if (!s1_if.waitrequest || !s2_if.waitrequest) wait_bad++;
      if (s1_if.readdatavalid) begin
        vcnt++;
        vcyc = cyc;
        vdata = s1_if.readdata;
      end
      clear_req = (cyc == 100);
      step();
      cyc++;
    end
    clear_req = 1'b0;
    chk("T5 busy cycles", 32'(n), 32'd1024);
    chk("T5 waitrequest", 32'(wait_bad), 32'd0);
    chk("T5 inflight count", 32'(vcnt), 32'd1);
    chk("T5 inflight cycle", 32'(vcyc), 32'd2);
    chk("T5 inflight data", vdata, 32'hDEADAAEF);
    rd_chk("T5 word5", 1, 11'd5, 32'h0);
    rd_chk("T5 word7", 2, 11'd7, 32'h0);
    rd_chk("T5 word20", 1, 11'd20, 32'h0);

    // T6: reset mid-fill restarts the fill from word 0
    wr(1, 11'd2, 32'hA5A5A5A5, 4'hF);
    rd_chk("T6 pre", 1, 11'd2, 32'hA5A5A5A5);
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    repeat (300) step();
    reset_n = 1'b0;
    #1;
    chk("T6 rst busy", 32'(clear_busy), 32'd1);
    chk("T6 rst rdata", s1_if.readdata, 32'h0);
    chk("T6 rst rvalid", 32'(s1_if.readdatavalid), 32'd0);
    step();
    reset_n = 1'b1;
    count_busy(n);
    chk("T6 fill cycles", 32'(n), 32'd1024);
    rd_chk("T6 word2", 1, 11'd2, 32'h0);
    rd_chk("T6 read 1024", 2, 11'd1024, 32'h0);
    rd_chk("T6 read 1023", 1, 11'd1023, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
